// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - direct-mapped write-through cache with fill FSM (optional DM_CACHE_PERF_EN hit/miss counters)
module dm_cache_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int SETS   = 8,
  parameter int WORDS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_en,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid
`ifdef DM_CACHE_PERF_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);

  localparam int OFF_W  = $clog2(WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - 1 - OFF_W - IDX_W;
  localparam int LINE_W = ADDR_W - 1 - OFF_W;

  typedef enum logic [1:0] {IDLE, FILL_REQ, FILL_WAIT, WR_WAIT} state_t;

  // Address fields of the current CPU request
  logic [OFF_W-1:0] cpu_off;
  logic [IDX_W-1:0] cpu_idx;
  logic [TAG_W-1:0] cpu_tag;
  // Byte-select bit is meaningless for 16-bit word accesses
  logic             unused_addr0;

  assign cpu_off      = cpu_addr[OFF_W:1];
  assign cpu_idx      = cpu_addr[OFF_W+IDX_W:OFF_W+1];
  assign cpu_tag      = cpu_addr[ADDR_W-1:OFF_W+IDX_W+1];
  assign unused_addr0 = cpu_addr[0];

  // Storage arrays (no reset needed on tag/data; valid bits gate their use)
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [DATA_W-1:0] data_q [SETS][WORDS];

  state_t              state_q, state_d;
  logic [SETS-1:0]     valid_q, valid_d;
  logic [OFF_W-1:0]    cnt_q, cnt_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [ADDR_W-2:0]   wr_addr_q, wr_addr_d;
  logic                wr_done_q, wr_done_d;
  logic                fill_done_q, fill_done_d;

  // Array write port controls
  logic                data_we;
  logic [IDX_W-1:0]    data_idx;
  logic [OFF_W-1:0]    data_off;
  logic [DATA_W-1:0]   data_wval;
  logic                tag_we;

  logic                hit;
  logic                same_wr;
  logic [IDX_W-1:0]    fill_idx;
  logic [TAG_W-1:0]    fill_tag;

  assign hit      = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign same_wr  = cpu_en && cpu_wr && (cpu_addr[ADDR_W-1:1] == wr_addr_q);
  assign fill_idx = line_q[IDX_W-1:0];
  assign fill_tag = line_q[LINE_W-1:IDX_W];

  // Next-state, array write controls and all CPU/memory-side outputs
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    wr_addr_d   = wr_addr_q;
    wr_done_d   = wr_done_q;
    fill_done_d = fill_done_q;
    data_we     = 1'b0;
    data_idx    = cpu_idx;
    data_off    = cpu_off;
    data_wval   = cpu_wdata;
    tag_we      = 1'b0;
    cpu_rdata   = '0;
    stall       = 1'b0;
    mem_en      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;

    case (state_q)
      IDLE: begin
        fill_done_d = 1'b0;
        // A completed write stays completed only while the same request is held
        if (!same_wr) wr_done_d = 1'b0;
        if (cpu_en) begin
          if (cpu_wr) begin
            if (!(wr_done_q && same_wr)) begin
              stall     = 1'b1;
              mem_en    = 1'b1;
              mem_wr    = 1'b1;
              mem_addr  = {cpu_addr[ADDR_W-1:1], 1'b0};
              mem_wdata = cpu_wdata;
              wr_addr_d = cpu_addr[ADDR_W-1:1];
              state_d   = WR_WAIT;
              data_we   = hit;
            end
          end else if (hit) begin
            cpu_rdata = data_q[cpu_idx][cpu_off];
          end else begin
            stall          = 1'b1;
            cnt_d          = '0;
            line_d         = cpu_addr[ADDR_W-1:OFF_W+1];
            // Line is overwritten word by word; keep it invalid until complete
            valid_d[cpu_idx] = 1'b0;
            state_d        = FILL_REQ;
          end
        end
      end
      FILL_REQ: begin
        stall    = 1'b1;
        mem_en   = 1'b1;
        mem_addr = {line_q, cnt_q, 1'b0};
        state_d  = FILL_WAIT;
      end
      FILL_WAIT: begin
        stall = 1'b1;
        if (mem_valid) begin
          data_we   = 1'b1;
          data_idx  = fill_idx;
          data_off  = cnt_q;
          data_wval = mem_rdata;
          if (cnt_q == OFF_W'(WORDS - 1)) begin
            tag_we            = 1'b1;
            valid_d[fill_idx] = 1'b1;
            fill_done_d       = 1'b1;
            state_d           = IDLE;
          end else begin
            cnt_d   = cnt_q + OFF_W'(1);
            state_d = FILL_REQ;
          end
        end
      end
      WR_WAIT: begin
        stall = 1'b1;
        if (mem_valid) begin
          wr_done_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset quiets every output and blocks array writes in the same cycle
    if (rst) begin
      data_we   = 1'b0;
      tag_we    = 1'b0;
      cpu_rdata = '0;
      stall     = 1'b0;
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      cnt_q       <= '0;
      line_q      <= '0;
      wr_addr_q   <= '0;
      wr_done_q   <= 1'b0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
      line_q      <= line_d;
      wr_addr_q   <= wr_addr_d;
      wr_done_q   <= wr_done_d;
      fill_done_q <= fill_done_d;
    end
  end

  // Tag and data array write ports
  always_ff @(posedge clk) begin
    if (data_we) data_q[data_idx][data_off] <= data_wval;
    if (tag_we) tag_q[fill_idx] <= fill_tag;
  end

`ifdef DM_CACHE_PERF_EN
  logic [15:0] hit_cnt_q, hit_cnt_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;
  logic        rd_done;

  // A read completes on its stall-free hit cycle; the first hit after a fill is the missed access
  assign rd_done = !rst && (state_q == IDLE) && cpu_en && !cpu_wr && hit;

  // Saturating per-access counters
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (rd_done && !fill_done_q && (hit_cnt_q != 16'hFFFF)) hit_cnt_d = hit_cnt_q + 16'd1;
    if (rd_done && fill_done_q && (miss_cnt_q != 16'hFFFF)) miss_cnt_d = miss_cnt_q + 16'd1;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb/tb_dm_cache_ctrl.sv - scoreboard testbench for dm_cache_ctrl
module tb_dm_cache_ctrl;
  localparam int WORDS = 8;
  localparam logic [15:0] LINE_MASK = ~16'(2 * WORDS - 1);

  logic        clk = 1'b0;
  logic        rst, cpu_en, cpu_wr;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        stall, mem_en, mem_wr, mem_valid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DM_CACHE_PERF_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  dm_cache_ctrl #(.ADDR_W(16), .DATA_W(16), .SETS(8), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall), .mem_en(mem_en),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_valid(mem_valid)
`ifdef DM_CACHE_PERF_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] addr;
    logic        wr;
    logic [15:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [15:0] rd_q[$];
  logic [15:0] mem_model [logic [15:0]];
  int          mem_lat  = 1;
  int          req_seen = 0;
  int          exp_hits = 0;
  int          exp_miss = 0;

  // Main-memory model: checks each request against the scoreboard, answers after mem_lat cycles
  req_t        re;
  logic [15:0] ra, rd;
  logic        rw;
  int          rl;
  initial begin
    mem_valid = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_en) begin
        ra = mem_addr; rw = mem_wr; rd = mem_wdata; rl = mem_lat;
        req_seen++;
        if (req_q.size() == 0) begin
          chk("mem_unexpected", 32'(ra), 32'hFFFF_FFFF);
        end else begin
          re = req_q.pop_front();
          chk("mem_addr", 32'(ra), 32'(re.addr));
          chk("mem_wr", 32'(rw), 32'(re.wr));
          if (re.wr) chk("mem_wdata", 32'(rd), 32'(re.wdata));
        end
        if (rw) mem_model[ra] = rd;
        repeat (rl) @(posedge clk);
        #1;
        mem_valid = 1'b1;
        mem_rdata = rw ? 16'h0 : (mem_model.exists(ra) ? mem_model[ra] : ra);
        @(posedge clk);
        #1;
        mem_valid = 1'b0;
        mem_rdata = '0;
      end
    end
  end

  task automatic push_fill(input logic [15:0] addr);
    for (int i = 0; i < WORDS; i++)
      req_q.push_back('{addr: (addr & LINE_MASK) | 16'(2 * i), wr: 1'b0, wdata: 16'h0});
  endtask

  task automatic do_load(input logic [15:0] addr, input logic [15:0] exp_data,
                         input bit miss, input string tag);
    int stalls = 0;
    bit done = 1'b0;
    if (miss) push_fill(addr);
    rd_q.push_back(exp_data);
    cpu_en = 1'b1; cpu_wr = 1'b0; cpu_addr = addr; cpu_wdata = '0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (stall) stalls++;
      else done = 1'b1;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_stall_cycles"}, 32'(stalls), miss ? 32'(2 * WORDS + 1) : 32'd0);
    chk({tag, "_rdata"}, 32'(cpu_rdata), 32'(rd_q.pop_front()));
    if (miss) exp_miss++;
    else exp_hits++;
    @(posedge clk);
    #1 cpu_en = 1'b0;
  endtask

  task automatic do_store(input logic [15:0] addr, input logic [15:0] data,
                          input int lat, input string tag);
    int stalls = 0;
    bit done = 1'b0;
    mem_lat = lat;
    req_q.push_back('{addr: addr & 16'hFFFE, wr: 1'b1, wdata: data});
    cpu_en = 1'b1; cpu_wr = 1'b1; cpu_addr = addr; cpu_wdata = data;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (stall) stalls++;
      else done = 1'b1;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_stall_cycles"}, 32'(stalls), 32'(lat + 1));
    // Held request must not be re-issued
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({tag, "_held_stall"}, 32'(stall), 32'd0);
    chk({tag, "_held_mem_en"}, 32'(mem_en), 32'd0);
    @(posedge clk);
    #1 cpu_en = 1'b0; cpu_wr = 1'b0;
    mem_lat = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int base;
  initial begin
    rst = 1'b1; cpu_en = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'h0042; cpu_wdata = 16'h1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
`ifdef DM_CACHE_PERF_EN
    chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
`endif
    @(posedge clk);
    #1 rst = 1'b0; cpu_en = 1'b0; cpu_wr = 1'b0;
    @(posedge clk);
    #1;

    do_load(16'h0010, 16'h0010, 1'b1, "ld010_miss");
    do_load(16'h0014, 16'h0014, 1'b0, "ld014_hit");
    do_load(16'h0110, 16'h0110, 1'b1, "ld110_miss");
    do_store(16'h0112, 16'hBEEF, 3, "st112_hit");
    do_load(16'h0112, 16'hBEEF, 1'b0, "ld112_hit");
    do_store(16'h0115, 16'h5A5A, 2, "st115_odd");
    do_load(16'h0114, 16'h5A5A, 1'b0, "ld114_hit");
    do_load(16'h0010, 16'h0010, 1'b1, "ld010_conflict");
    do_load(16'h0112, 16'hBEEF, 1'b1, "ld112_refill");
    do_store(16'h0200, 16'h1234, 1, "st200_miss");
    do_load(16'h0200, 16'h1234, 1'b1, "ld200_noalloc");
`ifdef DM_CACHE_PERF_EN
    chk("perf_hit_cnt", 32'(hit_cnt), 32'(exp_hits));
    chk("perf_miss_cnt", 32'(miss_cnt), 32'(exp_miss));
`endif

    // Reset in the middle of a fill, after three words have arrived
    mem_lat = 3;
    push_fill(16'h0030);
    base = req_seen;
    cpu_en = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h0030;
    for (int c = 0; c < 400 && req_seen < base + 4; c++) @(negedge clk);
    chk("abort_req_count", 32'(req_seen - base), 32'd4);
    @(posedge clk);
    #1 rst = 1'b1; cpu_en = 1'b0;
    @(negedge clk);
    chk("abort_rst_stall", 32'(stall), 32'd0);
    chk("abort_rst_mem_en", 32'(mem_en), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_hits = 0;
    exp_miss = 0;
    chk("abort_reqs_left", 32'(req_q.size()), 32'd4);
    req_q.delete();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("abort_idle_stall", 32'(stall), 32'd0);
    end
    mem_lat = 1;
    @(posedge clk);
    #1;
    do_load(16'h0030, 16'h0030, 1'b1, "ld030_after_rst");
    do_load(16'h0112, 16'hBEEF, 1'b1, "ld112_after_rst");
    do_load(16'h0034, 16'h0034, 1'b0, "ld034_hit");
`ifdef DM_CACHE_PERF_EN
    chk("perf_hit_cnt_end", 32'(hit_cnt), 32'(exp_hits));
    chk("perf_miss_cnt_end", 32'(miss_cnt), 32'(exp_miss));
`endif
    repeat (4) @(posedge clk);
    chk("reqs_outstanding", 32'(req_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
